// File: rtl/xbar_master_port.sv
// xbar_master_port: buffers master commands, arbitrates via req/grnt and issues single-beat slave transfers
module xbar_master_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              req,
  input  logic              grnt,
  output logic              s_valid,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              r_valid,
  output logic [DATA_W-1:0] r_rdata,
  output logic              r_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int EW = 1 + ADDR_W + DATA_W;
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  state_t state, state_nx;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tmr;
  logic push, pop, tmo, xfer, left, head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  assign {head_we, head_addr, head_wdata} = mem[rd_ptr];
  assign m_ready = (count != CW'(FIFO_DEPTH)) && !rst;
  assign push = m_valid && m_ready;
  assign xfer = state == XFER;
  assign tmo = xfer && !s_ack && grnt && tmr == TW'(ACK_TIMEOUT);
  assign pop = xfer && (s_ack || tmo);
  assign left = count > CW'(1) || push;
  assign s_valid = xfer;
  assign s_we = xfer && head_we;
  assign s_addr = xfer ? head_addr : '0;
  assign s_wdata = xfer ? head_wdata : '0;
  always_comb begin
    state_nx = state;
    if (state == IDLE && count != '0) state_nx = REQ;
    if (state == REQ && grnt) state_nx = XFER;
    if (xfer) state_nx = pop ? (left ? REQ : IDLE) : (grnt ? XFER : REQ);
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {m_we, m_addr, m_wdata};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      tmr <= '0;
      req <= 1'b0;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err <= 1'b0;
    end else begin
      state <= state_nx;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + CW'(push) - CW'(pop);
      tmr <= (xfer && state_nx == XFER) ? tmr + 1'b1 : '0;
      req <= state != IDLE;
      r_valid <= pop;
      r_rdata <= (xfer && s_ack && !head_we) ? s_rdata : '0;
      r_err <= tmo;
    end
  end
endmodule

// File: tb/tb_xbar_master_port.sv
// tb_xbar_master_port: directed self-checking bench for xbar_master_port
module tb_xbar_master_port;
  logic clk = 0, rst = 1, m_valid = 0, m_we = 0, grnt = 0, s_ack = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, s_rdata = 0;
  logic m_ready, req, s_valid, s_we, r_valid, r_err;
  logic [31:0] s_addr, s_wdata, r_rdata;
  int checks = 0, failures = 0;
  xbar_master_port dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .req(req), .grnt(grnt), .s_valid(s_valid),
    .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_ack(s_ack), .s_rdata(s_rdata),
    .r_valid(r_valid), .r_rdata(r_rdata), .r_err(r_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d);
    m_valid = 1;
    m_we = we;
    m_addr = a;
    m_wdata = d;
    tick();
    m_valid = 0;
  endtask
  initial begin
    int n;
    tick();
    tick();
    chk("rst_m_ready", m_ready, 0);
    chk("rst_outs", {req, s_valid, s_we, r_valid, r_err}, 0);
    chk("rst_data", {s_addr, s_wdata}, 0);
    chk("rst_rdata", r_rdata, 0);
    rst = 0;
    #1;
    chk("rel_m_ready", m_ready, 1);
    // single read
    push(0, 32'h10, 0);
    chk("rd_req_n", req, 0);
    tick();
    chk("rd_req_n1", req, 0);
    tick();
    chk("rd_req_n2", req, 1);
    chk("rd_sv_before", s_valid, 0);
    grnt = 1;
    tick();
    chk("rd_sv", {s_valid, s_we}, 2'b10);
    chk("rd_addr", s_addr, 32'h10);
    tick();
    tick();
    s_ack = 1;
    s_rdata = 32'hDEADBEEF;
    tick();
    s_ack = 0;
    chk("rd_rvalid", {r_valid, r_err, s_valid, req}, 4'b1001);
    chk("rd_rdata", r_rdata, 32'hDEADBEEF);
    tick();
    chk("rd_after", {r_valid, req, s_valid}, 0);
    grnt = 0;
    // back-to-back fill
    for (int i = 0; i < 4; i++) push(1, 32'h100 + i, i);
    chk("fill_full", m_ready, 0);
    m_valid = 1;
    m_we = 1;
    m_addr = 32'h104;
    m_wdata = 4;
    grnt = 1;
    tick();
    chk("fill_x0", {s_valid, s_we}, 2'b11);
    chk("fill_x0_addr", s_addr, 32'h100);
    chk("fill_still_full", m_ready, 0);
    s_ack = 1;
    s_rdata = 32'h55;
    tick();
    s_ack = 0;
    chk("fill_c0", {r_valid, r_err}, 2'b10);
    chk("fill_c0_rdata", r_rdata, 0);
    chk("fill_slot", m_ready, 1);
    tick();
    m_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      chk("fill_addr", {s_valid, s_addr}, {1'b1, 32'h100 + k});
      chk("fill_wdata", s_wdata, k);
      s_ack = 1;
      tick();
      s_ack = 0;
      chk("fill_c", {r_valid, r_err, s_valid}, 3'b100);
      chk("fill_c_rdata", r_rdata, 0);
      tick();
    end
    chk("fill_req_low", {req, r_valid, s_valid}, 0);
    grnt = 0;
    // grant loss and retry
    push(1, 32'h20, 32'hAA);
    tick();
    grnt = 1;
    tick();
    chk("gl_x", {s_valid, s_addr}, {1'b1, 32'h20});
    grnt = 0;
    tick();
    chk("gl_drop", {s_valid, r_valid, req}, 3'b001);
    tick();
    chk("gl_wait", {s_valid, r_valid}, 0);
    grnt = 1;
    tick();
    chk("gl_reissue", {s_valid, s_addr}, {1'b1, 32'h20});
    chk("gl_wdata", s_wdata, 32'hAA);
    s_ack = 1;
    tick();
    s_ack = 0;
    chk("gl_done", {r_valid, r_err}, 2'b10);
    tick();
    chk("gl_once", {r_valid, s_valid, req}, 0);
    grnt = 0;
    // timeout
    push(0, 32'h30, 0);
    tick();
    grnt = 1;
    tick();
    n = 0;
    while (s_valid && n < 40) begin
      n++;
      tick();
    end
    chk("to_len", n, 16);
    chk("to_comp", {r_valid, r_err}, 2'b11);
    chk("to_rdata", r_rdata, 0);
    tick();
    chk("to_popped", {r_valid, s_valid, req}, 0);
    grnt = 0;
    // simultaneous ack and grant drop
    push(0, 32'h40, 0);
    tick();
    grnt = 1;
    tick();
    chk("sim_x", s_valid, 1);
    s_ack = 1;
    s_rdata = 32'h1234;
    grnt = 0;
    tick();
    s_ack = 0;
    chk("sim_comp", {r_valid, r_err, s_valid}, 3'b100);
    chk("sim_rdata", r_rdata, 32'h1234);
    grnt = 1;
    tick();
    tick();
    chk("sim_noretry", {s_valid, r_valid, req}, 0);
    grnt = 0;
    // reset mid-transfer
    for (int i = 0; i < 3; i++) push(1, 32'h50 + i, i);
    grnt = 1;
    tick();
    chk("mr_x", {s_valid, s_addr}, {1'b1, 32'h50});
    rst = 1;
    tick();
    chk("mr_outs", {req, s_valid, s_we, r_valid, r_err, m_ready}, 0);
    chk("mr_data", {s_addr, s_wdata}, 0);
    rst = 0;
    tick();
    tick();
    tick();
    chk("mr_empty", {req, s_valid, r_valid, m_ready}, 4'b0001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xbar_master_port.md
# xbar_master_port

Master-side requester for the 2-master crossbar: buffers commands from one master, raises `req` toward the round-robin arbiter, waits for its `grnt` bit, then drives the single-beat transfer onto the shared slave bus. On slave acknowledge (or timeout) it pops the command and returns a completion to the master. One instance sits in front of each master, so bit *i* of the arbiter's `req`/`grnt` pair belongs to instance *i*.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `FIFO_DEPTH`, 4, command buffer depth (power of 2, ≥2)
- `ACK_TIMEOUT`, 15, max cycles in XFER without `s_ack` before error completion

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `m_valid`  in  1  master command valid
- `m_ready`  out  1  command accepted when `m_valid && m_ready`
- `m_we`  in  1  1 = write, 0 = read
- `m_addr`  in  ADDR_W  command address
- `m_wdata`  in  DATA_W  write data
- `req`  out  1  request to arbiter (this master's bit)
- `grnt`  in  1  grant from arbiter (this master's bit)
- `s_valid`  out  1  slave bus transfer valid
- `s_we`, `s_addr`, `s_wdata`  out  1/ADDR_W/DATA_W  head-of-FIFO command
- `s_ack`  in  1  slave completes transfer this cycle
- `s_rdata`  in  DATA_W  read data, valid with `s_ack`
- `r_valid`  out  1  one-cycle completion pulse
- `r_rdata`  out  DATA_W  read data (0 for writes and errors)
- `r_err`  out  1  completion was a timeout

## Operation
- FIFO of {we, addr, wdata}, FIFO_DEPTH entries, count width clog2(FIFO_DEPTH)+1. Push on `m_valid && m_ready`; pop only on completion. `m_ready = !full && !rst`, from registered count (pop in same cycle does not free a slot until next cycle).
- `req = 1` whenever FIFO non-empty and state ≠ IDLE-after-reset; registered.
- FSM states:
  - IDLE: `req=0`, `s_valid=0`. FIFO non-empty → REQ.
  - REQ: `req=1`. `grnt=1` → XFER, clear timeout counter.
  - XFER: `req=1`, `s_valid=1`, `s_*` = FIFO head. Each cycle counter+1.
    - `s_ack=1` → pop, `r_valid=1`, `r_rdata = s_we ? 0 : s_rdata`, `r_err=0`; → REQ if FIFO will still be non-empty, else IDLE.
    - else `grnt=0` (arbiter rotated away) → REQ; `s_valid` drops, entry NOT popped, retried later, counter cleared.
    - else counter == ACK_TIMEOUT → pop, `r_valid=1`, `r_rdata=0`, `r_err=1`; next state as for ack.
- Priority in XFER: `s_ack` > grant loss > timeout.
- Head entry is never modified while in XFER; pushes land at tail only.

## Timing
- Reset (`rst=1` at edge): state IDLE, FIFO empty, counter 0; `req=0`, `s_valid=0`, `s_we=0`, `s_addr=0`, `s_wdata=0`, `r_valid=0`, `r_rdata=0`, `r_err=0`; `m_ready=0` while `rst` high. Reset mid-transfer drops `s_valid` next cycle; pending commands lost, no completion issued.
- Push at edge N → `req=1` at N+2 (IDLE→REQ→req registered out).
- `grnt` sampled high at edge K → `s_valid=1` from K+1.
- `s_ack` at edge A → `r_valid` pulse cycle A+1, `s_valid=0` in A+1; with FIFO still non-empty and `grnt` still high, next `s_valid` at A+2.
- `s_valid` asserted only while previous-cycle `grnt` was 1.
- Timeout: `s_valid` high exactly ACK_TIMEOUT+1 cycles, then error completion.
- Full FIFO: `m_ready=0`; `m_valid` held, no loss. Empty after last pop: `req` falls the cycle after `r_valid`.

## Test plan
- Single read: push {we=0, addr=0x10}, `grnt=1` after 2 cycles, `s_ack` with `s_rdata=0xDEADBEEF` on 3rd XFER cycle → one `r_valid`, `r_rdata=0xDEADBEEF`, `r_err=0`, `req` low afterwards.
- Back-to-back fill: push 5 writes with `grnt=0` → 4 accepted, `m_ready=0` on 5th; after one ack, 5th accepted; all 5 complete in push order, `r_rdata=0`.
- Grant loss: XFER on write 0x20, drop `grnt` before `s_ack` → `s_valid=0` next cycle, no `r_valid`; regrant → same addr 0x20 reissued, then completes once.
- Timeout: `grnt=1`, never `s_ack` → `s_valid` high 16 cycles, then `r_valid=1`, `r_err=1`, `r_rdata=0`, entry popped.
- Simultaneous `s_ack` and `grnt` drop → completion taken (`r_valid=1`), no retry.
- Reset mid-XFER with 3 entries queued → next cycle all outputs 0, no `r_valid`, FIFO empty after reset release.
